// File: rtl/page_leaf_rr_mux.sv
// Leaf-side concentrator: per-child upstream FIFOs round-robin onto one BFT leaf port
// with resend hold/replay, plus a registered address demux from the leaf back to the children.
module page_leaf_rr_mux #(
    parameter int NUM_CH     = 4,
    parameter int PKT_W      = 49,
    parameter int SEL_W      = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [PKT_W-1:0]         din_leaf_bft2interface,
    output logic [PKT_W-1:0]         dout_leaf_interface2bft,
    input  logic                     resend,
    input  logic [NUM_CH*PKT_W-1:0]  din_child_interface2bft,
    output logic [NUM_CH*PKT_W-1:0]  dout_child_bft2interface,
    output logic [NUM_CH-1:0]        child_full,
    output logic [NUM_CH-1:0]        ovf_sticky,
    output logic                     bad_sel_sticky,
    output logic [CNT_W-1:0]         drop_count
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;
    localparam int DN_W = $clog2(NUM_CH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [DN_W-1:0]  k);
        logic [CNT_W+DN_W-1:0] s;
        s = {{DN_W{1'b0}}, a} + {{CNT_W{1'b0}}, k};
        if (s > {{DN_W{1'b0}}, {CNT_W{1'b1}}}) return '1;
        return s[CNT_W-1:0];
    endfunction

    logic [PKT_W-1:0] fifo_mem  [NUM_CH][FIFO_DEPTH];
    logic [AW-1:0]    wptr_p0   [NUM_CH];
    logic [AW-1:0]    rptr_p0   [NUM_CH];
    logic [CW-1:0]    cnt_p0    [NUM_CH];
    logic [CW-1:0]    cnt_nxt   [NUM_CH];
    logic [PKT_W-1:0] child_pkt [NUM_CH];
    logic [NUM_CH-1:0] push, drop, pop, nonempty;
    logic [DN_W-1:0]  drop_n;
    logic [CH_W-1:0]  last_grant, win;
    logic             win_vld, load;
    logic [PKT_W-1:0] leaf_pkt_p1;
    logic [NUM_CH*PKT_W-1:0] child_out_p1;

    always_comb begin
        drop_n = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            child_pkt[ch] = din_child_interface2bft[ch*PKT_W +: PKT_W];
            push[ch]      = child_pkt[ch][PKT_W-1] & ~child_full[ch];
            drop[ch]      = child_pkt[ch][PKT_W-1] & child_full[ch];
            nonempty[ch]  = (cnt_p0[ch] != '0);
            drop_n        = drop_n + DN_W'(drop[ch]);
        end
    end

    // The output register's valid bit doubles as the EMPTY/HOLD state.
    assign load = ~leaf_pkt_p1[PKT_W-1] | ~resend;

    always_comb begin
        win_vld = 1'b0;
        win     = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            if (!win_vld && nonempty[(int'(last_grant) + i) % NUM_CH]) begin
                win_vld = 1'b1;
                win     = CH_W'((int'(last_grant) + i) % NUM_CH);
            end
        end
    end

    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            pop[ch]     = load & win_vld & (win == CH_W'(ch));
            cnt_nxt[ch] = cnt_p0[ch] + CW'(push[ch]) - CW'(pop[ch]);
        end
    end

    // Stage p0: FIFO write
    always_ff @(posedge clk) begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (push[ch]) fifo_mem[ch][wptr_p0[ch]] <= child_pkt[ch];
        end
    end

    // Stage p0 -> p1: FIFO bookkeeping, arbitration and output register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                wptr_p0[ch] <= '0;
                rptr_p0[ch] <= '0;
                cnt_p0[ch]  <= '0;
            end
            child_full  <= '0;
            ovf_sticky  <= '0;
            drop_count  <= '0;
            last_grant  <= CH_W'(NUM_CH - 1);
            leaf_pkt_p1 <= '0;
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (push[ch]) wptr_p0[ch] <= wptr_p0[ch] + AW'(1);
                if (pop[ch])  rptr_p0[ch] <= rptr_p0[ch] + AW'(1);
                cnt_p0[ch]     <= cnt_nxt[ch];
                child_full[ch] <= (cnt_nxt[ch] == FULL_CNT);
            end
            ovf_sticky <= ovf_sticky | drop;
            drop_count <= sat_add(drop_count, drop_n);
            if (load) begin
                if (win_vld) begin
                    leaf_pkt_p1 <= fifo_mem[win][rptr_p0[win]];
                    last_grant  <= win;
                end else begin
                    leaf_pkt_p1 <= '0;
                end
            end
        end
    end

    assign dout_leaf_interface2bft = leaf_pkt_p1;

    logic             dn_vld, dn_sel_ok;
    logic [SEL_W-1:0] dn_sel;

    assign dn_vld    = din_leaf_bft2interface[PKT_W-1];
    assign dn_sel    = din_leaf_bft2interface[PKT_W-2 -: SEL_W];
    assign dn_sel_ok = ({1'b0, dn_sel} < (SEL_W+1)'(NUM_CH));

    // Stage p1: downstream demux register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            child_out_p1   <= '0;
            bad_sel_sticky <= 1'b0;
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                child_out_p1[ch*PKT_W +: PKT_W] <=
                    (dn_vld && dn_sel_ok && dn_sel == SEL_W'(ch)) ? din_leaf_bft2interface : '0;
            end
            if (dn_vld && !dn_sel_ok) bad_sel_sticky <= 1'b1;
        end
    end

    assign dout_child_bft2interface = child_out_p1;

endmodule

// File: tb/tb_page_leaf_rr_mux.sv
// Scoreboard bench for page_leaf_rr_mux: a 4-child instance for all traffic and a
// 3-child instance for the out-of-range select case.
`timescale 1ns/1ps
module tb_page_leaf_rr_mux;
    localparam int NUM_CH = 4, PKT_W = 49, SEL_W = 2, FIFO_DEPTH = 4, CNT_W = 8;
    localparam int WIDE = NUM_CH * PKT_W;

    logic clk = 1'b0, reset_n = 1'b0, resend = 1'b0;
    logic [PKT_W-1:0] din_leaf = '0, dout_leaf;
    logic [WIDE-1:0] din_child = '0, dout_child;
    logic [NUM_CH-1:0] child_full, ovf_sticky;
    logic bad_sel;
    logic [CNT_W-1:0] drop_count;

    logic [PKT_W-1:0] din_leaf3 = '0, dout_leaf3;
    logic [3*PKT_W-1:0] din_child3 = '0, dout_child3;
    logic [2:0] full3, ovf3;
    logic bad3;
    logic [CNT_W-1:0] drop3;

    page_leaf_rr_mux #(.NUM_CH(NUM_CH), .PKT_W(PKT_W), .SEL_W(SEL_W),
                       .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .din_leaf_bft2interface(din_leaf), .dout_leaf_interface2bft(dout_leaf),
        .resend(resend),
        .din_child_interface2bft(din_child), .dout_child_bft2interface(dout_child),
        .child_full(child_full), .ovf_sticky(ovf_sticky),
        .bad_sel_sticky(bad_sel), .drop_count(drop_count)
    );

    page_leaf_rr_mux #(.NUM_CH(3), .PKT_W(PKT_W), .SEL_W(SEL_W),
                       .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut3 (
        .clk(clk), .reset_n(reset_n),
        .din_leaf_bft2interface(din_leaf3), .dout_leaf_interface2bft(dout_leaf3),
        .resend(1'b0),
        .din_child_interface2bft(din_child3), .dout_child_bft2interface(dout_child3),
        .child_full(full3), .ovf_sticky(ovf3),
        .bad_sel_sticky(bad3), .drop_count(drop3)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_pass = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int at; logic [WIDE-1:0] v; } dn_t;
    logic [PKT_W-1:0] sb_q[$];
    dn_t dn_q[$];

    function automatic void chk(input string nm, input logic [WIDE-1:0] act,
                                input logic [WIDE-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endfunction

    function automatic logic [PKT_W-1:0] mk(input int tag);
        return {1'b1, 48'(tag)};
    endfunction

    // Monitor: a leaf packet is consumed when valid is shown with resend low.
    always @(negedge clk) begin
        if (reset_n) begin
            if (dout_leaf[PKT_W-1] && !resend) begin
                if (sb_q.size() == 0) chk("leaf_unexpected", WIDE'(dout_leaf), WIDE'(0));
                else chk("leaf_order", WIDE'(dout_leaf), WIDE'(sb_q.pop_front()));
            end
            while (dn_q.size() > 0 && dn_q[0].at <= cyc) begin
                if (dn_q[0].at == cyc) chk("child_demux", dout_child, dn_q[0].v);
                else chk("child_late", dout_child, dn_q[0].v);
                void'(dn_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        sb_q.delete();
        dn_q.delete();
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic send(input int ch, input logic [PKT_W-1:0] p);
        din_child[ch*PKT_W +: PKT_W] = p;
    endtask

    task automatic dn_drive(input logic [PKT_W-1:0] p, input logic [WIDE-1:0] exp);
        din_leaf = p;
        dn_q.push_back('{at: cyc + 1, v: exp});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [PKT_W-1:0] p1, b1, b2, v0, v1, v2, v3, w2;
        p1 = 49'h1_0000_0000_00AB;

        #1;
        chk("rst_dout_leaf", WIDE'(dout_leaf), WIDE'(0));
        chk("rst_dout_child", dout_child, WIDE'(0));
        chk("rst_child_full", WIDE'(child_full), WIDE'(0));
        chk("rst_ovf", WIDE'(ovf_sticky), WIDE'(0));
        chk("rst_bad_sel", WIDE'(bad_sel), WIDE'(0));
        chk("rst_drop", WIDE'(drop_count), WIDE'(0));
        repeat (2) tick();
        reset_n = 1'b1;
        tick();

        // single packet latency
        send(2, p1); sb_q.push_back(p1);
        tick(); send(2, '0);
        chk("lat_not_yet", WIDE'(dout_leaf), WIDE'(0));
        tick(); chk("lat_t2", WIDE'(dout_leaf), WIDE'(p1));
        tick(); chk("one_cycle", WIDE'(dout_leaf), WIDE'(0));

        // round-robin bursts
        do_reset();
        for (int b = 0; b < 2; b++) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                send(ch, mk(256 + 16*b + ch));
                sb_q.push_back(mk(256 + 16*b + ch));
            end
            tick(); din_child = '0;
            for (int i = 0; i < NUM_CH; i++) begin
                tick(); chk("rr_cycle", WIDE'(dout_leaf), WIDE'(mk(256 + 16*b + i)));
            end
        end
        tick(); chk("rr_idle", WIDE'(dout_leaf), WIDE'(0));

        // resend hold and replay
        b1 = mk(32'h201); b2 = mk(32'h202);
        send(1, b1); sb_q.push_back(b1); sb_q.push_back(b2);
        tick(); send(1, b2);
        tick(); din_child = '0; resend = 1'b1;
        chk("hold_first", WIDE'(dout_leaf), WIDE'(b1));
        for (int i = 0; i < 3; i++) begin
            tick(); chk("hold_stable", WIDE'(dout_leaf), WIDE'(b1));
        end
        resend = 1'b0;
        tick(); chk("after_resend", WIDE'(dout_leaf), WIDE'(b2));
        tick(); chk("resend_idle", WIDE'(dout_leaf), WIDE'(0));

        // overflow under resend
        resend = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send(0, mk(32'h300 + i));
            if (i < 5) sb_q.push_back(mk(32'h300 + i));
            tick();
            if (i == 4) begin
                chk("full_set", WIDE'(child_full), WIDE'(4'b0001));
                chk("ovf_before_drop", WIDE'(ovf_sticky), WIDE'(0));
            end
        end
        din_child = '0;
        chk("full_held", WIDE'(child_full), WIDE'(4'b0001));
        chk("ovf_set", WIDE'(ovf_sticky), WIDE'(4'b0001));
        chk("drop_one", WIDE'(drop_count), WIDE'(1));
        chk("ovf_dout_held", WIDE'(dout_leaf), WIDE'(mk(32'h300)));
        resend = 1'b0;
        tick(); chk("full_clear", WIDE'(child_full), WIDE'(0));
        repeat (6) tick();
        chk("drained_ovf", WIDE'(sb_q.size()), WIDE'(0));
        chk("ovf_sticky_kept", WIDE'(ovf_sticky), WIDE'(4'b0001));

        // downstream demux
        v0 = {1'b1, 2'd3, 46'h55};
        v1 = {1'b1, 2'd0, 46'hAA};
        v2 = {1'b0, 2'd2, 46'h77};
        v3 = {1'b1, 2'd1, 46'h1234};
        w2 = {1'b1, 2'd2, 46'h99};
        chk("bad3_pre", WIDE'(bad3), WIDE'(0));
        dn_drive(v0, WIDE'(v0) << (3*PKT_W)); din_leaf3 = v0;
        tick();
        chk("bad_sel_drop", WIDE'(dout_child3), WIDE'(0));
        chk("bad_sel_flag", WIDE'(bad3), WIDE'(1));
        chk("bad_sel_4ch", WIDE'(bad_sel), WIDE'(0));
        dn_drive(v1, WIDE'(v1)); din_leaf3 = w2;
        tick();
        chk("demux3_sel2", WIDE'(dout_child3), WIDE'(w2) << (2*PKT_W));
        dn_drive(v2, WIDE'(0)); din_leaf3 = '0;
        tick();
        dn_drive(v3, WIDE'(v3) << PKT_W);
        tick();
        dn_drive('0, WIDE'(0));
        repeat (2) tick();

        // reset with buffered packets and dout in HOLD
        resend = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(0, mk(32'h500 + i));
            tick();
        end
        din_child = '0;
        chk("pre_rst_full", WIDE'(child_full), WIDE'(4'b0001));
        chk("pre_rst_hold", WIDE'(dout_leaf), WIDE'(mk(32'h500)));
        #2;
        reset_n = 1'b0;
        sb_q.delete(); dn_q.delete();
        #1;
        chk("async_rst_dout", WIDE'(dout_leaf), WIDE'(0));
        chk("async_rst_full", WIDE'(child_full), WIDE'(0));
        chk("async_rst_drop", WIDE'(drop_count), WIDE'(0));
        chk("async_rst_ovf", WIDE'(ovf_sticky), WIDE'(0));
        resend = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(); chk("no_stale", WIDE'(dout_leaf), WIDE'(0));
        end

        for (int i = 0; i < 20 && (sb_q.size() != 0 || dn_q.size() != 0); i++) tick();
        chk("sb_empty", WIDE'(sb_q.size()), WIDE'(0));
        chk("dn_empty", WIDE'(dn_q.size()), WIDE'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
